afd_extractor: RTL and testbench

- Avalon-ST monitor that sits directly downstream of the AFD inserter (video, 20-bit symbols, ancillary words in data[19:10], data[9:0]=0x200) on the capture side of the loopback.
- Passes the stream through with zero latency.
- Parses type-13 ancillary control packets for SMPTE 2016 AFD (DID 0x41, SDID 0x05, DC 8).
- Checks the 9-bit checksum and commits decoded AFD/AR/bar data to Avalon-MM registers atomically.

---
 rtl/afd_extractor_if.sv | 34 +++
 rtl/afd_extractor.sv | 191 +++++++++++++++++++
 tb/tb_afd_extractor.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afd_extractor_if.sv
// Avalon-ST sink/source pair plus Avalon-MM register port of the AFD extractor.
// The slave modport is the extractor's view; master is the environment's view.
interface afd_extractor_if;
    logic        din_valid;
    logic [19:0] din_data;
    logic        din_sop;
    logic        din_eop;
    logic        din_ready;
    logic        dout_valid;
    logic [19:0] dout_data;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_ready;
    logic [3:0]  av_address;
    logic        av_read;
    logic [15:0] av_readdata;
    logic        av_write;
    logic [15:0] av_writedata;
    logic        afd_changed;

    modport slave (
        input  din_valid, din_data, din_sop, din_eop, dout_ready,
        input  av_address, av_read, av_write, av_writedata,
        output din_ready, dout_valid, dout_data, dout_sop, dout_eop,
        output av_readdata, afd_changed
    );

    modport master (
        output din_valid, din_data, din_sop, din_eop, dout_ready,
        output av_address, av_read, av_write, av_writedata,
        input  din_ready, dout_valid, dout_data, dout_sop, dout_eop,
        input  av_readdata, afd_changed
    );
endinterface

// File: rtl/afd_extractor.sv
// Zero-latency Avalon-ST monitor that decodes SMPTE 2016 AFD ancillary packets
// and commits AFD/AR/bar data atomically to Avalon-MM registers.
module afd_extractor #(
    parameter logic [7:0]  DID_VAL   = 8'h41,
    parameter logic [7:0]  SDID_VAL  = 8'h05,
    parameter int unsigned UDW_COUNT = 8
) (
    input  logic clk,
    input  logic rst_n,
    afd_extractor_if.slave bus
);
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_SKIP = 4'd1;
    localparam logic [3:0] ST_ADF1 = 4'd2;
    localparam logic [3:0] ST_ADF2 = 4'd3;
    localparam logic [3:0] ST_ADF3 = 4'd4;
    localparam logic [3:0] ST_DID  = 4'd5;
    localparam logic [3:0] ST_SDID = 4'd6;
    localparam logic [3:0] ST_DC   = 4'd7;
    localparam logic [3:0] ST_UDW  = 4'd8;
    localparam logic [3:0] ST_CKS  = 4'd9;

    assign bus.dout_valid = bus.din_valid;
    assign bus.dout_data  = bus.din_data;
    assign bus.dout_sop   = bus.din_sop;
    assign bus.dout_eop   = bus.din_eop;
    assign bus.din_ready  = bus.dout_ready;

    logic [3:0]  state, nxt, cur;
    logic        enable, act;
    logic [9:0]  w;
    logic [8:0]  p;
    logic [8:0]  acc;
    logic [2:0]  udw_cnt;
    logic [7:0]  shadow [8];
    logic        acc_clr, acc_add, cnt_clr, store, cks_eval, cks_ok, commit, cks_err;

    logic        valid, new_flag, chk_err, ar;
    logic [3:0]  afd, bar_flags;
    logic [15:0] bar1, bar2, rx_count, err_count, rd_mux;
    logic        wr_status, wr_rx, wr_err;

    assign act = bus.din_valid & bus.dout_ready & enable;
    assign w   = bus.din_data[19:10];
    assign p   = w[8:0];
    // A sop beat is always evaluated as if the parser were idle.
    assign cur = bus.din_sop ? ST_IDLE : state;

    always_comb begin
        nxt      = state;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        cnt_clr  = 1'b0;
        store    = 1'b0;
        cks_eval = 1'b0;
        if (act) begin
            nxt = cur;
            case (cur)
                ST_IDLE: if (bus.din_sop) nxt = (bus.din_data[3:0] == 4'd13) ? ST_ADF1 : ST_SKIP;
                ST_SKIP: nxt = ST_SKIP;
                ST_ADF1: nxt = (w == 10'h000) ? ST_ADF2 : ST_SKIP;
                ST_ADF2: nxt = (w == 10'h3FF) ? ST_ADF3 : ST_SKIP;
                ST_ADF3: begin
                    acc_clr = 1'b1;
                    nxt     = (w == 10'h3FF) ? ST_DID : ST_SKIP;
                end
                ST_DID: begin
                    acc_add = 1'b1;
                    nxt     = (w[7:0] == DID_VAL) ? ST_SDID : ST_SKIP;
                end
                ST_SDID: begin
                    acc_add = 1'b1;
                    nxt     = (w[7:0] == SDID_VAL) ? ST_DC : ST_SKIP;
                end
                ST_DC: begin
                    acc_add = 1'b1;
                    cnt_clr = 1'b1;
                    nxt     = (w[7:0] == 8'(UDW_COUNT)) ? ST_UDW : ST_SKIP;
                end
                ST_UDW: begin
                    acc_add = 1'b1;
                    store   = 1'b1;
                    if (udw_cnt == 3'(UDW_COUNT - 1)) nxt = ST_CKS;
                end
                ST_CKS: begin
                    cks_eval = 1'b1;
                    nxt      = ST_ADF1;
                end
                default: nxt = ST_IDLE;
            endcase
            // eop ends the Avalon packet from every state; a truncated packet simply drops its shadow.
            if (bus.din_eop) nxt = ST_IDLE;
        end
    end

    assign cks_ok  = (p == acc) && (w[9] == ~w[8]);
    assign commit  = cks_eval & cks_ok;
    assign cks_err = cks_eval & ~cks_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            udw_cnt <= '0;
            for (int unsigned i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (!enable) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
            if (acc_clr)      acc <= '0;
            else if (acc_add) acc <= acc + p;
            if (cnt_clr) begin
                udw_cnt <= '0;
            end else if (store) begin
                shadow[udw_cnt] <= w[7:0];
                udw_cnt         <= udw_cnt + 3'd1;
            end
        end
    end

    assign wr_status = bus.av_write && (bus.av_address == 4'd1);
    assign wr_rx     = bus.av_write && (bus.av_address == 4'd7);
    assign wr_err    = bus.av_write && (bus.av_address == 4'd8);

    always_comb begin
        rd_mux = '0;
        case (bus.av_address)
            4'd0: rd_mux = {15'd0, enable};
            4'd1: rd_mux = {13'd0, chk_err, new_flag, valid};
            4'd2: rd_mux = {12'd0, afd};
            4'd3: rd_mux = {15'd0, ar};
            4'd4: rd_mux = {12'd0, bar_flags};
            4'd5: rd_mux = bar1;
            4'd6: rd_mux = bar2;
            4'd7: rd_mux = rx_count;
            4'd8: rd_mux = err_count;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable          <= 1'b1;
            valid           <= 1'b0;
            new_flag        <= 1'b0;
            chk_err         <= 1'b0;
            afd             <= '0;
            ar              <= 1'b0;
            bar_flags       <= '0;
            bar1            <= '0;
            bar2            <= '0;
            rx_count        <= '0;
            err_count       <= '0;
            bus.av_readdata <= '0;
            bus.afd_changed <= 1'b0;
        end else begin
            bus.afd_changed <= 1'b0;
            if (bus.av_write && bus.av_address == 4'd0) enable <= bus.av_writedata[0];

            if (commit) begin
                valid           <= 1'b1;
                new_flag        <= 1'b1;
                afd             <= shadow[0][6:3];
                ar              <= shadow[0][2];
                bar_flags       <= shadow[3][7:4];
                bar1            <= {shadow[4], shadow[5]};
                bar2            <= {shadow[6], shadow[7]};
                bus.afd_changed <= !valid || (shadow[0][6:3] != afd);
            end else if (wr_status && bus.av_writedata[1]) begin
                new_flag <= 1'b0;
            end

            if (cks_err)                               chk_err <= 1'b1;
            else if (wr_status && bus.av_writedata[2]) chk_err <= 1'b0;

            if (commit) begin
                if (rx_count != '1) rx_count <= rx_count + 16'd1;
            end else if (wr_rx) begin
                rx_count <= '0;
            end

            if (cks_err) begin
                if (err_count != '1) err_count <= err_count + 16'd1;
            end else if (wr_err) begin
                err_count <= '0;
            end

            if (bus.av_read) bus.av_readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_afd_extractor.sv
// Self-checking bench for afd_extractor: stream scoreboard plus register vector tables.
module tb_afd_extractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    afd_extractor_if bus ();

    afd_extractor #(
        .DID_VAL  (8'h41),
        .SDID_VAL (8'h05),
        .UDW_COUNT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [19:0] d;
        logic        s;
        logic        e;
    } beat_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] exp;
    } vec_t;

    int          checks = 0;
    int          passed = 0;
    int          pulses = 0;
    bit          stall  = 1'b0;
    beat_t       sbq[$];
    vec_t        vecs[$];
    logic [19:0] pkt[$];
    logic [7:0]  u[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Stream scoreboard: every accepted beat must appear unchanged on the source.
    always @(negedge clk) begin
        if (rst_n && bus.din_valid && bus.dout_ready) begin
            if (sbq.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                beat_t b;
                b = sbq.pop_front();
                check("pass_beat", {bus.dout_valid, bus.dout_data, bus.dout_sop, bus.dout_eop},
                      {1'b1, b.d, b.s, b.e});
                check("pass_ready", {31'd0, bus.din_ready}, 32'd1);
            end
        end
        if (bus.afd_changed) pulses++;
    end

    function automatic logic [9:0] anc_w(input logic [7:0] b);
        return {~(^b), ^b, b};
    endfunction

    function automatic logic [19:0] wd(input logic [9:0] w);
        return {w, 10'h200};
    endfunction

    task automatic set_udw(input logic [3:0] afd, input logic ar, input logic [3:0] fl,
                           input logic [15:0] b1, input logic [15:0] b2);
        u[0] = {1'b0, afd, ar, 2'b00};
        u[1] = 8'h00;
        u[2] = 8'h00;
        u[3] = {fl, 4'h0};
        u[4] = b1[15:8];
        u[5] = b1[7:0];
        u[6] = b2[15:8];
        u[7] = b2[7:0];
    endtask

    task automatic new_pkt();
        pkt.delete();
        pkt.push_back(20'h0000D);
    endtask

    task automatic add_anc(input int n_udw, input int cks_off);
        logic [8:0] sum;
        logic [9:0] w;
        logic [7:0] hdr[3];
        hdr[0] = 8'h41; hdr[1] = 8'h05; hdr[2] = 8'h08;
        pkt.push_back(wd(10'h000));
        pkt.push_back(wd(10'h3FF));
        pkt.push_back(wd(10'h3FF));
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            w = anc_w(hdr[i]);
            sum = sum + w[8:0];
            pkt.push_back(wd(w));
        end
        for (int i = 0; i < n_udw; i++) begin
            w = anc_w(u[i]);
            sum = sum + w[8:0];
            pkt.push_back(wd(w));
        end
        if (n_udw == 8) begin
            sum = sum + 9'(cks_off);
            pkt.push_back(wd({~sum[8], sum}));
        end
    endtask

    task automatic drive(input logic [19:0] d, input logic s, input logic e);
        logic took;
        int   guard;
        guard = 0;
        bus.din_valid = 1'b1;
        bus.din_data  = d;
        bus.din_sop   = s;
        bus.din_eop   = e;
        sbq.push_back({d, s, e});
        do begin
            bus.dout_ready = (stall && guard < 20) ? ($urandom_range(0, 2) != 0) : 1'b1;
            took = bus.dout_ready;
            @(posedge clk); #1;
            guard++;
        end while (!took);
    endtask

    task automatic idle();
        bus.din_valid  = 1'b0;
        bus.din_sop    = 1'b0;
        bus.din_eop    = 1'b0;
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) drive(pkt[i], i == 0, i == pkt.size() - 1);
        idle();
        idle();
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [15:0] d);
        bus.av_address = a;
        bus.av_read    = 1'b1;
        @(posedge clk); #1;
        bus.av_read = 1'b0;
        d = bus.av_readdata;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [15:0] v);
        bus.av_address   = a;
        bus.av_writedata = v;
        bus.av_write     = 1'b1;
        @(posedge clk); #1;
        bus.av_write = 1'b0;
    endtask

    task automatic run_vecs(input string tag);
        logic [15:0] d;
        for (int i = 0; i < vecs.size(); i++) begin
            reg_read(vecs[i].addr, d);
            check($sformatf("%s_reg%0d", tag, vecs[i].addr), {16'd0, d}, {16'd0, vecs[i].exp});
        end
        vecs.delete();
    endtask

    task automatic add_vec(input logic [3:0] a, input logic [15:0] e);
        vec_t v;
        v.addr = a;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          p0;
        logic [15:0] d;
        bus.din_valid = 1'b1; bus.din_data = 20'h12345; bus.din_sop = 1'b1; bus.din_eop = 1'b0;
        bus.dout_ready = 1'b1; bus.av_address = '0; bus.av_read = 1'b0; bus.av_write = 1'b0;
        bus.av_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", {16'd0, bus.av_readdata}, 32'd0);
        check("rst_afd_changed", {31'd0, bus.afd_changed}, 32'd0);
        check("rst_passthrough", {bus.dout_valid, bus.dout_data, bus.dout_sop}, {1'b1, 20'h12345, 1'b1});
        bus.din_valid = 1'b0; bus.din_sop = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        add_vec(0, 16'h1);
        for (int a = 1; a <= 9; a++) add_vec(4'(a), 16'h0);
        run_vecs("reset");

        // Video packet that happens to contain ADF-like words, then a valid AFD packet.
        pkt.delete();
        pkt.push_back(20'h00000);
        pkt.push_back(wd(10'h000));
        pkt.push_back(wd(10'h3FF));
        pkt.push_back(wd(10'h3FF));
        pkt.push_back(wd(anc_w(8'h41)));
        send_pkt();
        p0 = pulses;
        set_udw(4'hA, 1'b1, 4'hC, 16'h1234, 16'hABCD);
        new_pkt(); add_anc(8, 0);
        send_pkt();
        check("t1_pulses", pulses - p0, 32'd1);
        add_vec(1, 16'h3); add_vec(2, 16'hA); add_vec(3, 16'h1); add_vec(4, 16'hC);
        add_vec(5, 16'h1234); add_vec(6, 16'hABCD); add_vec(7, 16'h1); add_vec(8, 16'h0);
        run_vecs("t1");
        bus.av_address = 4'd2;
        @(posedge clk); #1;
        check("readdata_hold", {16'd0, bus.av_readdata}, 32'd0);

        // Checksum off by one: no commit, error counted.
        p0 = pulses;
        set_udw(4'h3, 1'b0, 4'h1, 16'h5555, 16'h6666);
        new_pkt(); add_anc(8, 1);
        send_pkt();
        check("t2_pulses", pulses - p0, 32'd0);
        add_vec(1, 16'h7); add_vec(2, 16'hA); add_vec(5, 16'h1234); add_vec(7, 16'h1); add_vec(8, 16'h1);
        run_vecs("t2");
        reg_write(1, 16'h6);
        add_vec(1, 16'h1);
        run_vecs("t2clr");

        // Three back-to-back AFD packets in one Avalon packet.
        reg_write(7, 16'h0);
        p0 = pulses;
        new_pkt();
        set_udw(4'h2, 1'b0, 4'h0, 16'h0, 16'h0);
        add_anc(8, 0);
        add_anc(8, 0);
        set_udw(4'h8, 1'b1, 4'h3, 16'h0102, 16'h0304);
        add_anc(8, 0);
        send_pkt();
        check("t3_pulses", pulses - p0, 32'd2);
        add_vec(1, 16'h3); add_vec(2, 16'h8); add_vec(3, 16'h1); add_vec(4, 16'h3);
        add_vec(5, 16'h0102); add_vec(6, 16'h0304); add_vec(7, 16'h3); add_vec(8, 16'h1);
        run_vecs("t3");

        // Same packet with and without source backpressure.
        for (int pass = 0; pass < 2; pass++) begin
            reg_write(7, 16'h0);
            stall = (pass == 0);
            set_udw(4'h5, 1'b0, 4'h9, 16'hBEEF, 16'h0FF0);
            new_pkt(); add_anc(8, 0);
            send_pkt();
            stall = 1'b0;
            add_vec(2, 16'h5); add_vec(3, 16'h0); add_vec(4, 16'h9);
            add_vec(5, 16'hBEEF); add_vec(6, 16'h0FF0); add_vec(7, 16'h1);
            run_vecs(pass == 0 ? "t4stall" : "t4nostall");
        end

        // Truncated after 4th UDW, then a good packet.
        reg_write(8, 16'h0);
        reg_write(7, 16'h0);
        set_udw(4'h3, 1'b0, 4'h0, 16'h0, 16'h0);
        new_pkt(); add_anc(4, 0);
        send_pkt();
        set_udw(4'h6, 1'b1, 4'h0, 16'h0, 16'h0);
        new_pkt(); add_anc(8, 0);
        send_pkt();
        add_vec(7, 16'h1); add_vec(8, 16'h0); add_vec(2, 16'h6); add_vec(1, 16'h3);
        run_vecs("t5");

        // Status clear coinciding with a commit: the commit must win for 'new'.
        reg_write(1, 16'h2);
        add_vec(1, 16'h1);
        run_vecs("t6pre");
        set_udw(4'h9, 1'b0, 4'h0, 16'h0, 16'h0);
        new_pkt(); add_anc(8, 0);
        for (int i = 0; i < pkt.size() - 1; i++) drive(pkt[i], i == 0, 1'b0);
        bus.av_address = 4'd1; bus.av_writedata = 16'h6; bus.av_write = 1'b1;
        drive(pkt[pkt.size() - 1], 1'b0, 1'b1);
        bus.av_write = 1'b0;
        idle();
        add_vec(1, 16'h3); add_vec(2, 16'h9); add_vec(7, 16'h2);
        run_vecs("t6");

        // Disabled parser ignores a valid packet; re-enabling resumes decoding.
        reg_write(0, 16'h0);
        p0 = pulses;
        set_udw(4'hF, 1'b1, 4'h0, 16'h0, 16'h0);
        new_pkt(); add_anc(8, 0);
        send_pkt();
        check("t7_pulses", pulses - p0, 32'd0);
        add_vec(0, 16'h0); add_vec(7, 16'h2); add_vec(2, 16'h9);
        run_vecs("t7off");
        reg_write(0, 16'h1);
        send_pkt();
        add_vec(0, 16'h1); add_vec(7, 16'h3); add_vec(2, 16'hF);
        run_vecs("t7on");

        reg_read(4'd12, d);
        check("unmapped", {16'd0, d}, 32'd0);
        check("sb_drain", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
